// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers returned words in order and hands {instruction, pc} to decode.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] dwr_ptr_q, dwr_ptr_d;
  logic [PTR_W-1:0] pwr_ptr_q, pwr_ptr_d;
  logic [31:0]      data_q [BUF_DEPTH];
  logic [31:0]      pc_q   [BUF_DEPTH];

  logic in_fetch, redirect_ok, redirect_bad;
  logic issue, resp, push, pop;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (redirect && (redirect_pc[1:0] != 2'b00)) state_d = S_FAULT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_fault = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req    = !redirect && ((outstanding_q + count_q) < CNT_W'(BUF_DEPTH));
        instr_valid = (count_q != '0);
      end
      S_FAULT: fetch_fault = 1'b1;
      default: ;
    endcase
  end

  assign in_fetch     = (state_q == S_FETCH);
  assign redirect_ok  = in_fetch && redirect && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = in_fetch && redirect && (redirect_pc[1:0] != 2'b00);
  assign issue        = imem_req && imem_gnt;
  // A response with nothing outstanding is stale (e.g. from before reset) and ignored.
  assign resp         = imem_rvalid && (outstanding_q != '0);
  assign push         = resp && (drop_q == '0) && in_fetch && !redirect;
  assign pop          = instr_valid && id_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(resp);
    drop_d        = drop_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d      = rd_ptr_q;
    dwr_ptr_d     = dwr_ptr_q;
    pwr_ptr_d     = pwr_ptr_q;
    if (resp && (drop_q != '0)) drop_d    = drop_q - CNT_W'(1);
    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      pwr_ptr_d  = pwr_ptr_q + PTR_W'(1);
    end
    if (push) dwr_ptr_d = dwr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d  = rd_ptr_q + PTR_W'(1);
    // Any redirect flushes the buffer; everything still in flight must be discarded.
    if (redirect_ok || redirect_bad) begin
      drop_d    = outstanding_q - CNT_W'(resp);
      count_d   = '0;
      rd_ptr_d  = '0;
      dwr_ptr_d = '0;
      pwr_ptr_d = '0;
      if (redirect_ok) fetch_pc_d = redirect_pc;
    end
  end

  // NOTE: the buffer is tiny and its head drives the outputs, so it is reset to give defined zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      dwr_ptr_q     <= '0;
      pwr_ptr_q     <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      dwr_ptr_q     <= dwr_ptr_d;
      pwr_ptr_q     <= pwr_ptr_d;
      if (issue) pc_q[pwr_ptr_q]   <= fetch_pc_q;
      if (push)  data_q[dwr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_addr      = fetch_pc_q;
  assign instruction    = data_q[rd_ptr_q];
  assign instr_pc       = pc_q[rd_ptr_q];
  assign instr_pc_plus4 = instr_pc + 32'd4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a latency-programmable memory model plus
// a scoreboard of expected fetch PCs pushed at issue and popped at each handshake.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, id_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, fetch_fault;
  logic [31:0] instruction, instr_pc, instr_pc_plus4;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .instr_valid    (instr_valid),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        exp_fault;
  int          cyc, n_checks, n_fail, n_issue, n_deliver;
  logic        gnt_on, ready_on, rsp_on;
  int          lat;
  logic        redir_go, redir_on_coincide, redir_chk_req, chk_req_pending;
  logic [31:0] redir_target;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at the falling edge, sample just after, advance at the rising edge.
  task automatic cycle();
    logic redir_now;
    rsp_t r;
    @(negedge clk);
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rsp_on && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(pend_q[0].addr);
      pend_q.delete(0);
    end
    imem_gnt    = gnt_on;
    id_ready    = ready_on;
    redirect    = 1'b0;
    redirect_pc = redir_target;
    #1;
    redir_now = redir_go || (redir_on_coincide && imem_rvalid && instr_valid && id_ready);
    if (redir_now) begin
      redirect          = 1'b1;
      redir_go          = 1'b0;
      redir_on_coincide = 1'b0;
    end
    #1;
    check("fault_flag", fetch_fault, exp_fault);
    if (chk_req_pending) begin
      check("req_after_redirect", imem_req, 1'b1);
      check("addr_after_redirect", imem_addr, redir_target);
      chk_req_pending = 1'b0;
    end
    if (redir_now) check("req_during_redirect", imem_req, 1'b0);
    if (exp_fault) begin
      check("fault_req", imem_req, 1'b0);
      check("fault_valid", instr_valid, 1'b0);
    end
    if (imem_req && imem_gnt) begin
      check("issue_addr", imem_addr, exp_pc);
      r.addr = imem_addr;
      r.due  = cyc + lat;
      pend_q.push_back(r);
      exp_q.push_back(exp_pc);
      exp_pc += 32'd4;
      n_issue++;
    end
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", instr_valid, 1'b0);
      end else begin
        check("instr_pc", instr_pc, exp_q[0]);
        check("instruction", instruction, word_of(exp_q[0]));
        check("pc_plus4", instr_pc_plus4, exp_q[0] + 32'd4);
        if (id_ready) begin
          exp_q.delete(0);
          n_deliver++;
        end
      end
    end
    if (redir_now) begin
      exp_q.delete();
      if (redir_target[1:0] != 2'b00) exp_fault = 1'b1;
      else begin
        exp_pc = redir_target;
        if (redir_chk_req) chk_req_pending = 1'b1;
      end
      redir_chk_req = 1'b0;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asserts reset asynchronously mid-cycle and checks the cleared outputs immediately.
  task automatic do_reset(input bit keep_pend);
    @(negedge clk);
    reset       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    id_ready    = 1'b0;
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_fault", fetch_fault, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    exp_q.delete();
    if (!keep_pend) pend_q.delete();
    exp_pc            = RESET_PC;
    exp_fault         = 1'b0;
    redir_go          = 1'b0;
    redir_on_coincide = 1'b0;
    redir_chk_req     = 1'b0;
    chk_req_pending   = 1'b0;
    n_issue           = 0;
    n_deliver         = 0;
    @(posedge clk);
    cyc++;
  endtask

  // Stop issuing and let every outstanding word come back and be consumed.
  task automatic drain(input string tag);
    gnt_on   = 1'b0;
    ready_on = 1'b1;
    run(30);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    cyc = 0; n_checks = 0; n_fail = 0;
    gnt_on = 1'b0; ready_on = 1'b0; rsp_on = 1'b1; lat = 1;
    redir_target = '0;

    // Streaming fetch: gnt always, one-cycle memory, decode always ready.
    do_reset(1'b0);
    gnt_on = 1'b1; ready_on = 1'b1; lat = 1;
    run(20);
    check("t1_issue_count", (n_issue >= 8), 1'b1);
    drain("t1_drain");
    check("t1_delivered", n_deliver, n_issue);

    // Decode stalled: only BUF_DEPTH requests may go out; head holds.
    do_reset(1'b0);
    gnt_on = 1'b1; ready_on = 1'b0; lat = 1;
    run(8);
    check("t2_issue_count", n_issue, 2);
    #2;
    check("t2_req_low", imem_req, 1'b0);
    check("t2_valid_held", instr_valid, 1'b1);
    check("t2_head_pc", instr_pc, 32'h0);
    drain("t2_drain");
    check("t2_delivered", n_deliver, 2);

    // Redirect with two requests (8, C) in flight: both words must be dropped.
    do_reset(1'b0);
    gnt_on = 1'b1; ready_on = 1'b1; lat = 6;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (pend_q.size() == 2 && exp_pc == 32'h10) found = 1'b1;
    end
    check("t3_setup_reached", found, 1'b1);
    redir_target = 32'h100; redir_go = 1'b1;
    n_deliver = 0;
    run(30);
    check("t3_delivered_after", (n_deliver >= 2), 1'b1);
    drain("t3_drain");

    // Redirect in the same cycle as a handshake and a response.
    do_reset(1'b0);
    gnt_on = 1'b1; ready_on = 1'b1; lat = 1;
    redir_target = 32'h200; redir_on_coincide = 1'b1; redir_chk_req = 1'b1;
    run(20);
    check("t4_redirect_fired", redir_on_coincide, 1'b0);
    drain("t4_drain");

    // Misaligned redirect: sticky fault, everything quiet until reset.
    do_reset(1'b0);
    gnt_on = 1'b1; ready_on = 1'b1; lat = 3;
    run(5);
    redir_target = 32'h102; redir_go = 1'b1;
    run(14);
    check("t5_fault_sticky", fetch_fault, 1'b1);

    // PC wrap from the top of the address space.
    do_reset(1'b0);
    gnt_on = 1'b0; ready_on = 1'b1; lat = 1;
    run(2);
    redir_target = 32'hFFFF_FFFC; redir_go = 1'b1;
    run(1);
    gnt_on = 1'b1;
    run(10);
    check("t6_wrap_issues", (n_issue >= 3), 1'b1);
    drain("t6_wrap_drain");

    // Reset with a request in flight; its response arrives after release.
    do_reset(1'b0);
    gnt_on = 1'b1; ready_on = 1'b1; lat = 20;
    run(2);
    check("t6_inflight", pend_q.size(), 1);
    do_reset(1'b1);
    pend_q[0].due = 0;
    gnt_on = 1'b0;
    run(6);
    check("t6_late_sent", pend_q.size(), 0);
    #2;
    check("t6_no_valid", instr_valid, 1'b0);
    check("t6_no_delivery", n_deliver, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
